// File: rtl/demux1in2_reg.sv
// -----------------------------------------------------------------------------
// demux1in2_reg
// Registered 1-to-2 data router. A single valid/ready input stream is steered
// word by word to output port 0 or 1 according to i_control. Each output port
// is backed by its own 2-entry FIFO, so a stalled consumer on one port never
// blocks or loses data destined for the other.
//
// Ports:
//   i_clk      clock, all state updates on rising edge
//   i_rst      synchronous reset, active-high (wins over push/pop)
//   i_dat      input data word
//   i_control  destination select: 0 -> port 0, 1 -> port 1
//   i_valid    i_dat/i_control valid this cycle
//   o_ready    addressed FIFO (by i_control) is not full
//   o_dat0     port 0 head-of-FIFO data (0 when empty)
//   o_valid0   port 0 FIFO non-empty
//   i_ready0   port 0 consumer accepts o_dat0
//   o_dat1     port 1 head-of-FIFO data (0 when empty)
//   o_valid1   port 1 FIFO non-empty
//   i_ready1   port 1 consumer accepts o_dat1
// -----------------------------------------------------------------------------
module demux1in2_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_control,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_dat0,
    output logic             o_valid0,
    input  logic             i_ready0,
    output logic [WIDTH-1:0] o_dat1,
    output logic             o_valid1,
    input  logic             i_ready1
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [WIDTH-1:0] mem0 [2];
    logic [WIDTH-1:0] mem1 [2];
    logic             wr_ptr0, rd_ptr0;
    logic             wr_ptr1, rd_ptr1;
    logic [1:0]       count0, count1;

    logic push0, push1, pop0, pop1;

    // Full status is taken before any same-cycle pop: a full FIFO being
    // drained still refuses the incoming word (no bypass).
    always_comb begin
        o_ready = i_control ? (count1 != FULL) : (count0 != FULL);
    end

    always_comb begin
        push0 = i_valid && o_ready && !i_control;
        push1 = i_valid && o_ready &&  i_control;
        pop0  = o_valid0 && i_ready0;
        pop1  = o_valid1 && i_ready1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
            wr_ptr0 <= 1'b0;
            rd_ptr0 <= 1'b0;
            wr_ptr1 <= 1'b0;
            rd_ptr1 <= 1'b0;
            count0  <= '0;
            count1  <= '0;
        end else begin
            if (push0) begin
                mem0[wr_ptr0] <= i_dat;
                wr_ptr0       <= ~wr_ptr0;
            end
            if (pop0) begin
                rd_ptr0 <= ~rd_ptr0;
            end
            case ({push0, pop0})
                2'b10:   count0 <= count0 + 2'd1;
                2'b01:   count0 <= count0 - 2'd1;
                default: count0 <= count0;
            endcase

            if (push1) begin
                mem1[wr_ptr1] <= i_dat;
                wr_ptr1       <= ~wr_ptr1;
            end
            if (pop1) begin
                rd_ptr1 <= ~rd_ptr1;
            end
            case ({push1, pop1})
                2'b10:   count1 <= count1 + 2'd1;
                2'b01:   count1 <= count1 - 2'd1;
                default: count1 <= count1;
            endcase
        end
    end

    // Head data is zero-gated while the FIFO is empty.
    always_comb begin
        o_valid0 = (count0 != 2'd0);
        o_valid1 = (count1 != 2'd0);
        o_dat0   = o_valid0 ? mem0[rd_ptr0] : '0;
        o_dat1   = o_valid1 ? mem1[rd_ptr1] : '0;
    end

endmodule

// File: tb/tb_demux1in2_reg.sv
module tb_demux1in2_reg;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] dat;
    logic             control;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] dat0;
    logic             valid0;
    logic             ready0;
    logic [WIDTH-1:0] dat1;
    logic             valid1;
    logic             ready1;

    demux1in2_reg #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_dat     (dat),
        .i_control (control),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_dat0    (dat0),
        .o_valid0  (valid0),
        .i_ready0  (ready0),
        .o_dat1    (dat1),
        .o_valid1  (valid1),
        .i_ready1  (ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one cycle; exp_rdy is checked before the edge,
    // the remaining expectations just after it.
    typedef struct {
        logic             rst;
        logic             ctrl;
        logic             vld;
        logic [WIDTH-1:0] d;
        logic             r0;
        logic             r1;
        logic             exp_rdy;
        logic             exp_v0;
        logic [WIDTH-1:0] exp_d0;
        logic             exp_v1;
        logic [WIDTH-1:0] exp_d1;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input int idx,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst     = v.rst;
        control = v.ctrl;
        valid   = v.vld;
        dat     = v.d;
        ready0  = v.r0;
        ready1  = v.r1;
        #1;
        cmp("o_ready", idx, {31'd0, ready}, {31'd0, v.exp_rdy});
        @(posedge clk);
        #1;
        cmp("o_valid0", idx, {31'd0, valid0}, {31'd0, v.exp_v0});
        cmp("o_dat0",   idx, dat0, v.exp_d0);
        cmp("o_valid1", idx, {31'd0, valid1}, {31'd0, v.exp_v1});
        cmp("o_dat1",   idx, dat1, v.exp_d1);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; control = 1'b0; valid = 1'b0; dat = '0;
        ready0 = 1'b0; ready1 = 1'b0;

        //         rst ctrl vld  d      r0 r1  rdy  v0 d0     v1 d1
        // single route
        tbl.push_back('{0, 0, 1, 122,   1, 1,  1,   1, 122,   0, 0});
        tbl.push_back('{0, 1, 1, 54,    1, 1,  1,   0, 0,     1, 54});
        tbl.push_back('{0, 1, 0, 0,     1, 1,  1,   0, 0,     0, 0});
        // back-pressure / full on port 1
        tbl.push_back('{0, 1, 1, 574,   1, 0,  1,   0, 0,     1, 574});
        tbl.push_back('{0, 1, 1, 290,   1, 0,  1,   0, 0,     1, 574});
        tbl.push_back('{0, 1, 1, 5789,  1, 0,  0,   0, 0,     1, 574});
        tbl.push_back('{0, 1, 1, 5789,  1, 1,  0,   0, 0,     1, 290});
        tbl.push_back('{0, 1, 1, 5789,  1, 1,  1,   0, 0,     1, 5789});
        tbl.push_back('{0, 1, 0, 0,     1, 1,  1,   0, 0,     0, 0});
        // independent ports: port 0 full, port 1 still accepts
        tbl.push_back('{0, 0, 1, 331,   0, 1,  1,   1, 331,   0, 0});
        tbl.push_back('{0, 0, 1, 125,   0, 1,  1,   1, 331,   0, 0});
        tbl.push_back('{0, 0, 1, 999,   0, 1,  0,   1, 331,   0, 0});
        tbl.push_back('{0, 1, 1, 64,    0, 0,  1,   1, 331,   1, 64});
        tbl.push_back('{0, 1, 0, 0,     0, 1,  1,   1, 331,   0, 0});
        tbl.push_back('{0, 0, 0, 0,     1, 0,  0,   1, 125,   0, 0});
        // push+pop on port 0 at count 1, streaming across pointer wrap
        tbl.push_back('{0, 0, 1, 31,    1, 0,  1,   1, 31,    0, 0});
        tbl.push_back('{0, 0, 1, 62,    1, 0,  1,   1, 62,    0, 0});
        tbl.push_back('{0, 0, 1, 90,    1, 0,  1,   1, 90,    0, 0});
        tbl.push_back('{0, 0, 1, 98,    1, 0,  1,   1, 98,    0, 0});
        tbl.push_back('{0, 0, 1, 9422,  1, 0,  1,   1, 9422,  0, 0});
        tbl.push_back('{0, 0, 0, 0,     1, 0,  1,   0, 0,     0, 0});
        // ready while empty: no underflow
        tbl.push_back('{0, 0, 0, 0,     1, 1,  1,   0, 0,     0, 0});
        tbl.push_back('{0, 1, 0, 0,     1, 1,  1,   0, 0,     0, 0});

        // reset then idle, o_ready checked for both control values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("rst_valid0", 0, {31'd0, valid0}, '0);
        cmp("rst_dat0",   0, dat0, '0);
        cmp("rst_valid1", 0, {31'd0, valid1}, '0);
        cmp("rst_dat1",   0, dat1, '0);
        control = 1'b0; #1;
        cmp("rst_ready_c0", 0, {31'd0, ready}, 32'd1);
        control = 1'b1; #1;
        cmp("rst_ready_c1", 0, {31'd0, ready}, 32'd1);

        foreach (tbl[i]) apply(tbl[i], i);

        // reset mid-operation with both FIFOs full and a push presented
        apply('{0, 0, 1, 437, 0, 0, 1, 1, 437, 0, 0},   100);
        apply('{0, 0, 1, 12,  0, 0, 1, 1, 437, 0, 0},   101);
        apply('{0, 1, 1, 976, 0, 0, 1, 1, 437, 1, 976}, 102);
        apply('{0, 1, 1, 210, 0, 0, 1, 1, 437, 1, 976}, 103);
        apply('{1, 0, 1, 902, 1, 1, 0, 0, 0,   0, 0},   104);
        apply('{0, 0, 0, 0,   0, 0, 1, 0, 0,   0, 0},   105);
        apply('{0, 1, 0, 0,   0, 0, 1, 0, 0,   0, 0},   106);
        // first word after reset must be the fresh one, not 902
        apply('{0, 0, 1, 7,   0, 0, 1, 1, 7,   0, 0},   107);
        apply('{0, 0, 0, 0,   1, 0, 1, 0, 0,   0, 0},   108);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1in2_reg.md
Name: demux1in2_reg

Overview:
Registered 1-to-2 data router: the distributing counterpart of the 2-to-1 data mux. It takes a single valid/ready input stream and steers each word to output port 0 or 1 according to i_control. Each output port has its own 2-entry FIFO, so one stalled consumer does not lose data. Used in the MIPS core wherever one producer (e.g. writeback/result bus) feeds two independent consumers.

Parameters:
WIDTH, 32, data width of input and both outputs
DEPTH, 2, entries per output FIFO (fixed at 2 for this revision; pointers are 1 bit, counts are 2 bits)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_dat  input  WIDTH  input data word
i_control  input  1  destination select: 0 -> port 0, 1 -> port 1
i_valid  input  1  i_dat/i_control valid this cycle
o_ready  output  1  router can accept the word currently addressed by i_control
o_dat0  output  WIDTH  port 0 head-of-FIFO data
o_valid0  output  1  port 0 FIFO non-empty
i_ready0  input  1  port 0 consumer accepts o_dat0
o_dat1  output  WIDTH  port 1 head-of-FIFO data
o_valid1  output  1  port 1 FIFO non-empty
i_ready1  input  1  port 1 consumer accepts o_dat1

Behaviour:
- Reset (i_rst=1 at clock edge): both FIFOs emptied (counts=0, read/write pointers=0, storage cleared to 0); o_valid0=o_valid1=0; o_dat0=o_dat1=0. i_rst has priority over every push/pop in the same cycle, including reset mid-transfer: any queued words are discarded.
- o_ready = (i_control ? count1 : count0) != DEPTH; combinational from current count and i_control only. It does not depend on i_ready0/1 and does not depend on i_valid.
- Push: when i_valid && o_ready at the clock edge, i_dat is written into the FIFO selected by i_control, that write pointer advances (wraps 1->0), and its count increments. Only one FIFO is written per cycle.
- Pop, per port N: when o_validN && i_readyN at the clock edge, the read pointer advances (wraps 1->0) and countN decrements. Ports pop independently; both may pop in the same cycle.
- Simultaneous push and pop on the same port: count unchanged, both pointers advance. This is allowed only when the FIFO is not full, because o_ready is computed before the pop. A full FIFO that is being popped still presents o_ready=0 for that cycle (no bypass).
- o_validN = (countN != 0). o_datN = storage[rd_ptrN] when countN != 0, otherwise 0 (zero-gated).
- Latency: an accepted word is visible on o_datN with o_validN=1 on the cycle after the accepting edge. There is no combinational path from i_dat to o_dat.
- Ordering: words are delivered in acceptance order per port. No ordering is defined between ports.
- i_readyN while o_validN=0: ignored; count never underflows.
- i_valid=0: i_dat and i_control are don't-care; no state change except pops.
- Output data is stable while o_validN=1 and i_readyN=0.

Test Plan:
- Reset then idle: assert i_rst 2 cycles -> o_valid0=o_valid1=0, o_dat0=o_dat1=0, o_ready=1 for both i_control values.
- Single route: i_control=0, i_dat=122, i_valid=1 for 1 cycle, i_ready0=1 -> next cycle o_valid0=1, o_dat0=122, o_valid1=0. Then i_control=1, i_dat=54 -> o_dat1=54 one cycle later.
- Back-pressure/full: i_ready1=0, push 574, 290, 5789 to port 1 on consecutive cycles -> 574 and 290 accepted, o_ready=0 on the third cycle, 5789 held by the source. Raise i_ready1 -> outputs 574, 290, then 5789 in order.
- Independent ports: port 0 full (331, 125) with i_ready0=0, then i_control=1, i_dat=64 -> o_ready=1, 64 appears on o_dat1; o_dat0 stays 331.
- Push+pop same port, count=1: port 0 holds 31, push 62 with i_ready0=1 -> count stays 1, o_dat0=62 next cycle. Wrap-around: continue streaming 90, 98, 9422 -> delivered in order.
- Reset mid-operation: both FIFOs hold 2 words (437, 12 / 976, 210), assert i_rst alongside i_valid=1 and i_dat=902 -> after the edge all valids=0, data=0, 902 not stored.
